// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states,
// load-stream target encoding and the width of the run-cycle counter.
package loader_pkg;

    // Width of the run-cycle status counter.
    localparam int RUN_CNT_W = 32;

    // Loader sequencing: stream the program in, let the core run, then
    // park in one of two terminal states until the next reset.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        TIMEOUT = 2'd3
    } state_e;

    // Destination of a load-stream beat.
    typedef enum logic {
        TGT_IMEM = 1'b0,
        TGT_RF   = 1'b1
    } target_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear. Counts one per
// enabled cycle and holds at all-ones instead of wrapping.
module sat_counter
    import loader_pkg::*;
#(
    parameter int W = RUN_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance when enabled unless already pinned at the top.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (en && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: accepts a stream of words destined for instruction memory
// or the register file, writes them out one cycle after acceptance, then
// releases the core from reset and supervises it until it halts or runs out
// of its cycle budget.
module prog_loader
    import loader_pkg::*;
#(
    parameter int IMEM_AW    = 8,
    parameter int XLEN       = 32,
    parameter int RF_AW      = 5,
    parameter int MAX_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [XLEN-1:0]      s_data,
    input  logic                 s_target,
    input  logic                 s_last,

    output logic                 imem_we,
    output logic [IMEM_AW-1:0]   imem_addr,
    output logic [XLEN-1:0]      imem_wdata,

    output logic                 rf_we,
    output logic [RF_AW-1:0]     rf_addr,
    output logic [XLEN-1:0]      rf_wdata,

    output logic                 core_rst,
    input  logic                 halt,

    output logic                 done,
    output logic                 timeout,
    output logic                 overflow,
    output logic [RUN_CNT_W-1:0] run_cycles
);

    // Value the counter shows in the cycle before the budget is used up;
    // seeing it while counting means this is the last permitted cycle.
    localparam logic [RUN_CNT_W-1:0] LAST_RUN_CNT = RUN_CNT_W'(MAX_CYCLES - 1);

    state_e               state_q, state_d;

    // Write pointers; the full flag records that the last address has
    // already been written so further beats are dropped instead of wrapping.
    logic [IMEM_AW-1:0]   imem_cnt_q, imem_cnt_d;
    logic                 imem_full_q, imem_full_d;
    logic [RF_AW-1:0]     rf_cnt_q, rf_cnt_d;
    logic                 rf_full_q, rf_full_d;

    // Registered write ports.
    logic                 imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [XLEN-1:0]      imem_wdata_q, imem_wdata_d;
    logic                 rf_we_q, rf_we_d;
    logic [RF_AW-1:0]     rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]      rf_wdata_q, rf_wdata_d;

    logic                 core_rst_q, core_rst_d;
    logic                 overflow_q, overflow_d;

    logic                 accept;
    logic                 run_en;
    logic [RUN_CNT_W-1:0] run_cnt;

    assign s_ready = (state_q == LOAD) && !rst;
    assign accept  = s_valid && s_ready;

    // The core is counted as running only once its reset has been released.
    assign run_en  = (state_q == RUN) && !core_rst_q;

    sat_counter #(
        .W     (RUN_CNT_W)
    ) u_run_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (run_en),
        .count (run_cnt)
    );

    // Next state: leave LOAD on the last beat; in RUN a halt from the live
    // core beats an expiring budget; DONE and TIMEOUT hold until reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: begin
                if (accept && s_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_en && halt) begin
                    state_d = DONE;
                end else if (run_en && (run_cnt == LAST_RUN_CNT)) begin
                    state_d = TIMEOUT;
                end
            end
            DONE:    state_d = DONE;
            TIMEOUT: state_d = TIMEOUT;
            default: state_d = LOAD;
        endcase

        // Core reset drops only after a full cycle in RUN, so the final
        // program write lands before the core starts fetching.
        core_rst_d = !((state_q == RUN) && (state_d == RUN));
    end

    // Write path: route an accepted beat to its target, or drop it and
    // flag overflow when that target has no address left.
    always_comb begin
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_cnt_d   = imem_cnt_q;
        imem_full_d  = imem_full_q;
        rf_we_d      = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        rf_cnt_d     = rf_cnt_q;
        rf_full_d    = rf_full_q;
        overflow_d   = overflow_q;

        if (accept) begin
            if (target_e'(s_target) == TGT_IMEM) begin
                if (imem_full_q) begin
                    overflow_d = 1'b1;
                end else begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = imem_cnt_q;
                    imem_wdata_d = s_data;
                    if (imem_cnt_q == '1) begin
                        imem_full_d = 1'b1;
                    end else begin
                        imem_cnt_d  = imem_cnt_q + IMEM_AW'(1);
                    end
                end
            end else begin
                if (rf_full_q) begin
                    overflow_d = 1'b1;
                end else begin
                    rf_we_d    = 1'b1;
                    rf_addr_d  = rf_cnt_q;
                    rf_wdata_d = s_data;
                    if (rf_cnt_q == '1) begin
                        rf_full_d = 1'b1;
                    end else begin
                        rf_cnt_d  = rf_cnt_q + RF_AW'(1);
                    end
                end
            end
        end
    end

    // State, pointers and registered ports, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            imem_cnt_q   <= '0;
            imem_full_q  <= 1'b0;
            rf_cnt_q     <= '0;
            rf_full_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            rf_we_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            core_rst_q   <= 1'b1;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            imem_cnt_q   <= imem_cnt_d;
            imem_full_q  <= imem_full_d;
            rf_cnt_q     <= rf_cnt_d;
            rf_full_q    <= rf_full_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            rf_we_q      <= rf_we_d;
            rf_addr_q    <= rf_addr_d;
            rf_wdata_q   <= rf_wdata_d;
            core_rst_q   <= core_rst_d;
            overflow_q   <= overflow_d;
        end
    end

    // Outputs are masked by rst directly so that a write registered just
    // before reset is never presented, and the reset values appear from the
    // very first cycle rst is high rather than one edge later.
    assign imem_we    = imem_we_q && !rst;
    assign imem_addr  = rst ? '0 : imem_addr_q;
    assign imem_wdata = rst ? '0 : imem_wdata_q;
    assign rf_we      = rf_we_q && !rst;
    assign rf_addr    = rst ? '0 : rf_addr_q;
    assign rf_wdata   = rst ? '0 : rf_wdata_q;
    assign core_rst   = core_rst_q || rst;
    assign done       = (state_q == DONE) && !rst;
    assign timeout    = (state_q == TIMEOUT) && !rst;
    assign overflow   = overflow_q && !rst;
    assign run_cycles = rst ? '0 : run_cnt;

    // One beat per cycle means the two write ports never fire together.
    a_single_write: assert property (@(posedge clk) disable iff (rst)
        !(imem_we_q && rf_we_q));

    // The run counter stops at the budget because RUN is left there.
    a_budget_bound: assert property (@(posedge clk) disable iff (rst)
        run_cnt <= RUN_CNT_W'(MAX_CYCLES));

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes the expected writes
// (target, address, data, cycle) into a queue and a negedge monitor pops and
// compares each write the DUT presents. Status outputs are checked inline.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int IMEM_AW    = 2;
    localparam int XLEN       = 32;
    localparam int RF_AW      = 5;
    localparam int MAX_CYCLES = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic [XLEN-1:0]      s_data;
    logic                 s_target;
    logic                 s_last;
    logic                 imem_we;
    logic [IMEM_AW-1:0]   imem_addr;
    logic [XLEN-1:0]      imem_wdata;
    logic                 rf_we;
    logic [RF_AW-1:0]     rf_addr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 core_rst;
    logic                 halt;
    logic                 done;
    logic                 timeout;
    logic                 overflow;
    logic [RUN_CNT_W-1:0] run_cycles;

    typedef struct {
        bit              tgt;
        int              addr;
        logic [XLEN-1:0] data;
        int              cyc;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    prog_loader #(
        .IMEM_AW    (IMEM_AW),
        .XLEN       (XLEN),
        .RF_AW      (RF_AW),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_target   (s_target),
        .s_last     (s_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .core_rst   (core_rst),
        .halt       (halt),
        .done       (done),
        .timeout    (timeout),
        .overflow   (overflow),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_wait(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: every write the DUT shows must match the head of the queue.
    always @(negedge clk) begin
        wr_t         e;
        logic [31:0] act_addr;
        logic [31:0] act_data;
        if (imem_we || rf_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: imem_we=%0b rf_we=%0b at cycle %0d, expected none",
                         imem_we, rf_we, cyc);
            end else begin
                e        = sb.pop_front();
                act_addr = rf_we ? 32'(rf_addr) : 32'(imem_addr);
                act_data = rf_we ? rf_wdata : imem_wdata;
                check("wr_both_ports", 32'(imem_we && rf_we), 0);
                check("wr_target", 32'(rf_we), 32'(e.tgt));
                check("wr_addr", act_addr, e.addr);
                check("wr_data", act_data, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Reset for one edge while presenting a beat; verify reset outputs.
    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b1;
        halt     = 1'b0;
        s_valid  = 1'b1;
        s_target = 1'b0;
        s_last   = 1'b1;
        s_data   = 32'hdead_beef;
        @(posedge clk); #1;
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_rf_addr", 32'(rf_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_run_cycles", run_cycles, 0);
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        check("ready_after_rst", 32'(s_ready), 1);
    endtask

    // Present one beat for one cycle; queue its write if one is expected.
    task automatic send(input bit tgt, input logic [XLEN-1:0] data, input bit last,
                        input bit exp_wr, input int exp_addr);
        @(posedge clk); #1;
        check("s_ready_load", 32'(s_ready), 1);
        s_valid  = 1'b1;
        s_target = tgt;
        s_data   = data;
        s_last   = last;
        if (exp_wr) sb.push_back('{tgt: tgt, addr: exp_addr, data: data, cyc: cyc + 1});
    endtask

    // After the last beat: core_rst stays high one cycle, then falls.
    task automatic finish_load(input bit pulse_halt);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (pulse_halt) halt = 1'b1;
        check("core_rst_first_run", 32'(core_rst), 1);
        check("s_ready_run", 32'(s_ready), 0);
        @(posedge clk); #1;
        halt = 1'b0;
        check("core_rst_fall", 32'(core_rst), 0);
        check("run_cycles_start", run_cycles, 0);
        check("done_early", 32'(done), 0);
    endtask

    task automatic wait_run_cycles(input int target);
        for (int i = 0; i < 40; i++) begin
            if (run_cycles == 32'(target)) return;
            @(posedge clk); #1;
        end
        fail_wait("wait_run_cycles");
    endtask

    task automatic wait_terminal();
        for (int i = 0; i < 40; i++) begin
            if (done || timeout) return;
            @(posedge clk); #1;
        end
        fail_wait("wait_terminal");
    endtask

    task automatic check_drained(input string name);
        repeat (2) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_target = 1'b0;
        s_last   = 1'b0;
        halt     = 1'b0;
        do_reset();

        // Three imem words, halt in the first RUN cycle is ignored, halt later ends the run.
        send(1'b0, 32'h0020_8033, 1'b0, 1'b1, 0);
        send(1'b0, 32'h0031_0133, 1'b0, 1'b1, 1);
        send(1'b0, 32'h0000_0073, 1'b1, 1'b1, 2);
        finish_load(1'b1);
        wait_run_cycles(3);
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        check("t1_done", 32'(done), 1);
        check("t1_timeout", 32'(timeout), 0);
        check("t1_run_cycles", run_cycles, 4);
        check("t1_core_rst", 32'(core_rst), 1);
        s_valid  = 1'b1;
        s_target = 1'b0;
        s_last   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t1_ready_done", 32'(s_ready), 0);
        check("t1_done_hold", 32'(done), 1);
        check("t1_run_hold", run_cycles, 4);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check_drained("t1_drained");

        // Interleaved imem / rf beats, then run out the budget.
        do_reset();
        send(1'b0, 32'h0000_0aa1, 1'b0, 1'b1, 0);
        send(1'b1, 32'h0000_0005, 1'b0, 1'b1, 0);
        send(1'b0, 32'h0000_0aa2, 1'b0, 1'b1, 1);
        send(1'b1, 32'h0000_0007, 1'b0, 1'b1, 1);
        send(1'b0, 32'h0000_0aa3, 1'b1, 1'b1, 2);
        finish_load(1'b0);
        wait_terminal();
        check("t2_timeout", 32'(timeout), 1);
        check("t2_done", 32'(done), 0);
        check("t2_run_cycles", run_cycles, MAX_CYCLES);
        check("t2_core_rst", 32'(core_rst), 1);
        halt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        halt = 1'b0;
        check("t2_timeout_hold", 32'(timeout), 1);
        check("t2_done_hold", 32'(done), 0);
        check("t2_run_hold", run_cycles, MAX_CYCLES);
        check_drained("t2_drained");

        // Halt on the very cycle the budget expires: halt wins.
        do_reset();
        send(1'b1, 32'h0000_0abc, 1'b1, 1'b1, 0);
        finish_load(1'b0);
        wait_run_cycles(MAX_CYCLES - 1);
        halt = 1'b1;
        @(posedge clk); #1;
        halt = 1'b0;
        check("t3_done", 32'(done), 1);
        check("t3_timeout", 32'(timeout), 0);
        check("t3_run_cycles", run_cycles, MAX_CYCLES);
        check_drained("t3_drained");

        // Five imem beats into a four-word imem: fifth dropped, overflow sticks.
        do_reset();
        send(1'b0, 32'h0000_0011, 1'b0, 1'b1, 0);
        send(1'b0, 32'h0000_0022, 1'b0, 1'b1, 1);
        send(1'b0, 32'h0000_0033, 1'b0, 1'b1, 2);
        send(1'b0, 32'h0000_0044, 1'b0, 1'b1, 3);
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("t4_no_overflow", 32'(overflow), 0);
        send(1'b0, 32'h0000_0055, 1'b1, 1'b0, 0);
        finish_load(1'b0);
        check("t4_overflow", 32'(overflow), 1);
        repeat (4) @(posedge clk);
        #1;
        check("t4_overflow_sticky", 32'(overflow), 1);
        check_drained("t4_drained");

        // Reset mid-load after two beats; the pending write is abandoned.
        do_reset();
        send(1'b0, 32'h0000_00aa, 1'b0, 1'b1, 0);
        send(1'b0, 32'h0000_00bb, 1'b0, 1'b0, 0);
        do_reset();
        send(1'b0, 32'h0000_00cc, 1'b1, 1'b1, 0);
        finish_load(1'b0);
        check("t5_overflow", 32'(overflow), 0);
        repeat (3) @(posedge clk);
        #1;
        check("t5_run_cycles", run_cycles, 3);
        check_drained("t5_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter IMEM_AW, default 8, meaning instruction-memory word-address width (depth 2**IMEM_AW).
REQ-002 SHALL have parameter XLEN, default 32, meaning data width of load stream, imem and register-file words.
REQ-003 SHALL have parameter RF_AW, default 5, meaning register-file address width (2**RF_AW registers).
REQ-004 SHALL have parameter MAX_CYCLES, default 100, meaning run-cycle budget before timeout (>=1).
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have ports s_valid input 1, s_ready output 1, s_data input XLEN, s_target input 1 (0=imem, 1=regfile), s_last input 1: the load stream.
REQ-008 SHALL have ports imem_we output 1, imem_addr output IMEM_AW, imem_wdata output XLEN: the imem write port.
REQ-009 SHALL have ports rf_we output 1, rf_addr output RF_AW, rf_wdata output XLEN: the register-file write port.
REQ-010 SHALL have port core_rst  output  1  reset to the processor core.
REQ-011 SHALL have port halt  input  1  core halt indication, sampled only in RUN.
REQ-012 SHALL have ports done output 1, timeout output 1, overflow output 1, run_cycles output 32: status.

Function
REQ-013 SHALL implement FSM states LOAD, RUN, DONE, TIMEOUT; LOAD is the reset state.
REQ-014 SHALL drive s_ready=1 only in LOAD; a beat is accepted when s_valid&&s_ready.
REQ-015 SHALL keep independent imem and regfile address counters, both starting at 0 and advancing by 1 per accepted beat of their target.
REQ-016 SHALL register writes: a beat accepted in cycle T produces we=1, the current counter address and s_data on the selected port in T+1; we=0 otherwise.
REQ-017 SHALL, on an accepted beat whose target counter already wrote its last address (2**AW-1), suppress the write, not wrap, and set sticky overflow.
REQ-018 SHALL, on an accepted beat with s_last=1, move to RUN in T+1; core_rst SHALL deassert in T+2, after the last write.
REQ-019 SHALL hold core_rst=1 in LOAD, DONE, TIMEOUT, and in the first RUN cycle.
REQ-020 SHALL increment run_cycles once per cycle with core_rst=0; run_cycles SHALL saturate and hold outside RUN.
REQ-021 SHALL go RUN->DONE when halt=1 with core_rst=0, and RUN->TIMEOUT when run_cycles reaches MAX_CYCLES; halt wins when both occur in the same cycle.
REQ-022 SHALL assert done in DONE and timeout in TIMEOUT; both states SHALL be terminal until rst.
REQ-023 SHALL ignore s_valid, s_target and s_last outside LOAD, and ignore halt outside RUN.

Reset
REQ-024 SHALL, while rst=1, force state LOAD, both address counters 0, run_cycles 0, imem_we=rf_we=0, imem_addr/rf_addr/wdata 0, core_rst=1, done=timeout=overflow=0, s_ready=0.
REQ-025 SHALL drive s_ready=1 in the first cycle after rst deasserts.
REQ-026 SHALL, on rst mid-load or mid-run, abandon the operation without emitting a pending write; the next load SHALL start again at address 0.

Structure
REQ-027 SHALL take the state enum, target enum (TGT_IMEM, TGT_RF) and run_cycles width constant from shared package loader_pkg.
REQ-028 SHALL be one flat module; the saturating run-cycle counter MAY be sub-module sat_counter.

Verification
REQ-029 Load 3 imem words 0x00208033, 0x00310133, 0x00000073 (last on 3rd) -> imem_we pulses at addr 0,1,2 one cycle after each accept; core_rst falls 2 cycles after 3rd accept.
REQ-030 Interleave rf beats 5, 7 with imem beats -> rf writes x0=5, x1=7; imem addresses contiguous and unaffected.
REQ-031 MAX_CYCLES=10, halt never asserted -> timeout=1 with run_cycles=10; done=0; core_rst returns to 1.
REQ-032 halt asserted on the same cycle run_cycles reaches MAX_CYCLES -> done=1, timeout=0.
REQ-033 IMEM_AW=2, 5 imem beats -> writes at 0..3 only, 5th suppressed, overflow=1 and sticky.
REQ-034 rst pulsed after 2 accepted beats, then reload 1 beat with s_last -> write at addr 0, overflow=0, run_cycles restarts at 0.
